// File: rtl/fwft_pkt_reader_pkg.sv
// Shared types for the FWFT packet reader.
// The PAD state is only present when FWFT_PKT_READER_PAD_EN is defined.
package fwft_pkt_reader_pkg;

    localparam int PKT_DATA_WIDTH = 8;

`ifdef FWFT_PKT_READER_PAD_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_PAD    = 2'd2
    } pkt_state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1
    } pkt_state_e;
`endif

    typedef struct packed {
        logic [PKT_DATA_WIDTH-1:0] data;
        logic                      last;
        logic                      pad;
    } pkt_beat_t;

endpackage

// File: rtl/fwft_pkt_reader_if.sv
// Valid/ready packet stream carrying data, last and pad markers.
interface fwft_pkt_reader_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;
    logic                  m_last;
    logic                  m_pad;

    modport master (output m_data, output m_valid, output m_last, output m_pad, input m_ready);
    modport slave  (input m_data, input m_valid, input m_last, input m_pad, output m_ready);
endinterface

// File: rtl/fwft_pkt_reader_skid_buf.sv
// Two-entry FIFO-ordered output buffer of packet beats; the registered
// occupancy lets the producer decide pushes without looking at the sink's ready.
module pkt_skid_buf
    import fwft_pkt_reader_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  pkt_beat_t push_beat,
    output pkt_beat_t head_beat,
    output logic      head_valid,
    input  logic      head_ready,
    output logic [1:0] buf_count
);

    logic       rd_ptr_reg;
    logic       wr_ptr_reg;
    logic [1:0] count_reg;
    logic [1:0] count_next;
    logic       push_ok;
    logic       pop;
    pkt_beat_t  entry_data [2];

    assign push_ok    = push && (count_reg != 2'd2);
    assign head_valid = (count_reg != 2'd0);
    assign pop        = head_valid && head_ready;
    assign head_beat  = entry_data[rd_ptr_reg];
    assign buf_count  = count_reg;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_entry
            pkt_beat_t entry_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    entry_reg <= '0;
                end else if (push_ok && (wr_ptr_reg == 1'(gi))) begin
                    entry_reg <= push_beat;
                end
            end

            assign entry_data[gi] = entry_reg;
        end
    endgenerate

    always_comb begin
        count_next = count_reg;
        case ({push_ok, pop})
            2'b10:   count_next = count_reg + 2'd1;
            2'b01:   count_next = count_reg - 2'd1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_reg <= 1'b0;
            wr_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (push_ok) wr_ptr_reg <= ~wr_ptr_reg;
            if (pop)     rd_ptr_reg <= ~rd_ptr_reg;
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/fwft_pkt_reader.sv
// Pops a FWFT FIFO into fixed-length packets on a valid/ready stream with last.
// Define FWFT_PKT_READER_PAD_EN to pad out packets whose FIFO runs dry for TIMEOUT_CYCLES.
module fwft_pkt_reader
    import fwft_pkt_reader_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int LEN_WIDTH      = 8,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int PAD_VALUE      = 0
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  pkt_len,
    fwft_pkt_reader_if.master     m,
    output logic                  busy
);

    generate
        if (DATA_WIDTH != PKT_DATA_WIDTH) begin : g_bad_data_width
            $error("DATA_WIDTH must equal fwft_pkt_reader_pkg::PKT_DATA_WIDTH");
        end
        if ((TIMEOUT_CYCLES < 1) || (PAD_VALUE < 0) ||
            (longint'(PAD_VALUE) >= (longint'(1) << DATA_WIDTH))) begin : g_bad_params
            $error("TIMEOUT_CYCLES must be >= 1 and PAD_VALUE must fit in DATA_WIDTH");
        end
    endgenerate

    pkt_state_e           state_reg;
    logic [LEN_WIDTH-1:0] len_reg;
    logic [LEN_WIDTH-1:0] fetched_reg;
    logic [1:0]           buf_count;
    logic                 push;
    logic                 beat_last;
    pkt_beat_t            push_beat;
    pkt_beat_t            head_beat;

    assign beat_last  = (fetched_reg == (len_reg - LEN_WIDTH'(1)));
    // Depends only on registered state and fifo_empty, never on m_ready.
    assign fifo_rd_en = (state_reg == ST_STREAM) && !fifo_empty && (buf_count < 2'd2);
    assign busy       = (state_reg != ST_IDLE);

`ifdef FWFT_PKT_READER_PAD_EN
    localparam int                    STARVE_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [DATA_WIDTH-1:0] PAD_DATA = DATA_WIDTH'(PAD_VALUE);

    logic [STARVE_W-1:0] starve_reg;
    logic                pad_push;

    assign pad_push = (state_reg == ST_PAD) && (buf_count < 2'd2);
    assign push     = fifo_rd_en || pad_push;

    always_comb begin
        push_beat      = '0;
        push_beat.data = pad_push ? PAD_DATA : fifo_dout;
        push_beat.last = beat_last;
        push_beat.pad  = pad_push;
    end
`else
    assign push = fifo_rd_en;

    always_comb begin
        push_beat      = '0;
        push_beat.data = fifo_dout;
        push_beat.last = beat_last;
        push_beat.pad  = 1'b0;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            len_reg     <= '0;
            fetched_reg <= '0;
`ifdef FWFT_PKT_READER_PAD_EN
            starve_reg  <= '0;
`endif
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start && (pkt_len != '0)) begin
                        len_reg     <= pkt_len;
                        fetched_reg <= '0;
                        state_reg   <= ST_STREAM;
`ifdef FWFT_PKT_READER_PAD_EN
                        starve_reg  <= '0;
`endif
                    end
                end
                ST_STREAM: begin
                    if (fifo_rd_en) begin
                        fetched_reg <= fetched_reg + LEN_WIDTH'(1);
                        if (beat_last) state_reg <= ST_IDLE;
                    end
`ifdef FWFT_PKT_READER_PAD_EN
                    // A full buffer with a non-empty FIFO is back-pressure, not starvation.
                    if (fifo_rd_en) begin
                        starve_reg <= '0;
                    end else if (fifo_empty) begin
                        if (starve_reg == STARVE_W'(TIMEOUT_CYCLES - 1)) begin
                            state_reg <= ST_PAD;
                        end else begin
                            starve_reg <= starve_reg + STARVE_W'(1);
                        end
                    end
`endif
                end
`ifdef FWFT_PKT_READER_PAD_EN
                ST_PAD: begin
                    if (pad_push) begin
                        fetched_reg <= fetched_reg + LEN_WIDTH'(1);
                        if (beat_last) state_reg <= ST_IDLE;
                    end
                end
`endif
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    pkt_skid_buf u_skid_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_beat  (push_beat),
        .head_beat  (head_beat),
        .head_valid (m.m_valid),
        .head_ready (m.m_ready),
        .buf_count  (buf_count)
    );

    assign m.m_data = head_beat.data;
    assign m.m_last = head_beat.last;
    assign m.m_pad  = head_beat.pad;

endmodule

// File: tb/tb_fwft_pkt_reader.sv
// Directed bench for fwft_pkt_reader: behavioural FWFT FIFO source, stream
// monitor logging one line per beat, and hand-computed expected beats.
`timescale 1ns/1ps
module tb_fwft_pkt_reader;

    localparam int DW   = 8;
    localparam int LW   = 8;
    localparam int TO   = 16;
    localparam int PADV = 'hA5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] fifo_dout;
    logic          fifo_empty;
    logic          fifo_rd_en;
    logic          start;
    logic [LW-1:0] pkt_len;
    logic          busy;

    fwft_pkt_reader_if #(.DATA_WIDTH(DW)) s_if ();

    fwft_pkt_reader #(
        .DATA_WIDTH     (DW),
        .LEN_WIDTH      (LW),
        .TIMEOUT_CYCLES (TO),
        .PAD_VALUE      (PADV)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo_dout  (fifo_dout),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .start      (start),
        .pkt_len    (pkt_len),
        .m          (s_if.master),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int         n_total = 0;
    int         n_bad = 0;
    int         cyc = 0;
    int         pop_cnt = 0;
    int         viol_empty = 0;
    int         viol_idle = 0;
    logic [7:0] fifo_q [$];
    logic [9:0] rx_q [$];
    int         rx_cyc [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic int getcyc(input int idx);
        return (idx < rx_q.size()) ? rx_cyc[idx] : -1;
    endfunction

    task automatic chk_beat(input int idx, input logic [7:0] d, input logic l, input logic p,
                            input string tag);
        logic [9:0] b;
        b = (idx < rx_q.size()) ? rx_q[idx] : 10'h3FF;
        chk({tag, "_data"}, 32'(b[9:2]), 32'(d));
        chk({tag, "_last"}, 32'(b[1]), 32'(l));
        chk({tag, "_pad"},  32'(b[0]), 32'(p));
    endtask

    function automatic void fifo_refresh();
        fifo_empty = (fifo_q.size() == 0);
        fifo_dout  = fifo_empty ? 8'hEE : fifo_q[0];
    endfunction

    task automatic fifo_push(input logic [7:0] w);
        fifo_q.push_back(w);
        fifo_refresh();
    endtask

    task automatic pulse_start(input logic [7:0] len, output int c);
        @(negedge clk);
        start   = 1'b1;
        pkt_len = len;
        @(negedge clk);
        start = 1'b0;
        c     = cyc;
    endtask

    task automatic wait_rx(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while ((rx_q.size() < n) && (k < budget)) begin
            @(negedge clk);
            k++;
        end
        if (rx_q.size() < n) chk(tag, 32'(rx_q.size()), 32'(n));
    endtask

    // Stream/FIFO monitor: samples pre-edge values, updates the FIFO model just after.
    initial begin
        logic pop_now;
        forever begin
            @(posedge clk);
            cyc++;
            pop_now = 1'b0;
            if (rst_n) begin
                if (s_if.m_valid && s_if.m_ready) begin
                    rx_q.push_back({s_if.m_data, s_if.m_last, s_if.m_pad});
                    rx_cyc.push_back(cyc);
                    $display("beat %0d @cyc %0d: data=0x%02h last=%0b pad=%0b",
                             rx_q.size() - 1, cyc, s_if.m_data, s_if.m_last, s_if.m_pad);
                end
                if (fifo_rd_en) begin
                    pop_now = 1'b1;
                    if (fifo_empty) viol_empty++;
                    if (!busy) viol_idle++;
                end
            end
            #1;
            if (pop_now && (fifo_q.size() > 0)) begin
                void'(fifo_q.pop_front());
                pop_cnt++;
            end
            fifo_refresh();
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int c0;
        int p0;
        bit b_sent;

        start       = 1'b0;
        pkt_len     = '0;
        s_if.m_ready = 1'b0;
        fifo_refresh();

        // Reset state, FIFO already holding the first packet
        for (int i = 0; i < 4; i++) fifo_push(8'(8'h10 + i));
        repeat (3) @(negedge clk);
        chk("rst_m_valid", 32'(s_if.m_valid), 32'd0);
        chk("rst_m_last",  32'(s_if.m_last),  32'd0);
        chk("rst_m_pad",   32'(s_if.m_pad),   32'd0);
        chk("rst_m_data",  32'(s_if.m_data),  32'd0);
        chk("rst_busy",    32'(busy),         32'd0);
        chk("rst_rd_en",   32'(fifo_rd_en),   32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_no_pop", 32'(pop_cnt), 32'd0);

        // T1: len 4, ready high, full FIFO
        s_if.m_ready = 1'b1;
        base = rx_q.size();
        pulse_start(8'd4, c0);
        wait_rx(base + 4, 20, "t1_timeout");
        for (int i = 0; i < 4; i++) chk_beat(base + i, 8'(8'h10 + i), (i == 3), 1'b0, "t1");
        chk("t1_first_latency", 32'(getcyc(base)), 32'(c0 + 2));
        chk("t1_back_to_back", 32'(getcyc(base + 3) - getcyc(base)), 32'd3);
        @(negedge clk);
        chk("t1_busy_done", 32'(busy), 32'd0);
        chk("t1_pops", 32'(pop_cnt), 32'd4);

        // T2: len 3 with sink stalled
        s_if.m_ready = 1'b0;
        for (int i = 0; i < 3; i++) fifo_push(8'(8'h20 + i));
        p0 = pop_cnt;
        base = rx_q.size();
        pulse_start(8'd3, c0);
        repeat (6) @(negedge clk);
        chk("t2_two_pops", 32'(pop_cnt - p0), 32'd2);
        chk("t2_rd_en_low", 32'(fifo_rd_en), 32'd0);
        chk("t2_m_valid", 32'(s_if.m_valid), 32'd1);
        chk("t2_head", 32'(s_if.m_data), 32'h20);
        chk("t2_no_xfer", 32'(rx_q.size()), 32'(base));
        s_if.m_ready = 1'b1;
        wait_rx(base + 3, 20, "t2_timeout");
        for (int i = 0; i < 3; i++) chk_beat(base + i, 8'(8'h20 + i), (i == 2), 1'b0, "t2");

        // T3: back-to-back packets (2 then 1) with ready toggling every cycle
        s_if.m_ready = 1'b0;
        fifo_push(8'h30);
        fifo_push(8'h31);
        fifo_push(8'h40);
        p0 = pop_cnt;
        base = rx_q.size();
        b_sent = 1'b0;
        for (int i = 0; (i < 40) && (rx_q.size() < base + 3); i++) begin
            @(negedge clk);
            s_if.m_ready = ~s_if.m_ready;
            start = 1'b0;
            if (i == 0) begin
                start   = 1'b1;
                pkt_len = 8'd2;
            end else if (!b_sent && !busy) begin
                start   = 1'b1;
                pkt_len = 8'd1;
                b_sent  = 1'b1;
            end
        end
        @(negedge clk);
        start = 1'b0;
        s_if.m_ready = 1'b1;
        wait_rx(base + 3, 10, "t3_timeout");
        repeat (3) @(negedge clk);
        chk("t3_b_started", 32'(b_sent), 32'd1);
        chk_beat(base,     8'h30, 1'b0, 1'b0, "t3_a0");
        chk_beat(base + 1, 8'h31, 1'b1, 1'b0, "t3_a1");
        chk_beat(base + 2, 8'h40, 1'b1, 1'b0, "t3_b0");
        chk("t3_no_dup", 32'(rx_q.size()), 32'(base + 3));
        chk("t3_pops", 32'(pop_cnt - p0), 32'd3);

        // T4: zero-length start is ignored
        fifo_push(8'h50);
        p0 = pop_cnt;
        pulse_start(8'd0, c0);
        repeat (3) @(negedge clk);
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_no_pop", 32'(pop_cnt - p0), 32'd0);
        chk("t4_no_valid", 32'(s_if.m_valid), 32'd0);

        // T5: FIFO runs dry after one of four beats
        s_if.m_ready = 1'b1;
        base = rx_q.size();
        pulse_start(8'd4, c0);
`ifdef FWFT_PKT_READER_PAD_EN
        wait_rx(base + 4, 40, "t5_timeout");
        chk_beat(base, 8'h50, 1'b0, 1'b0, "t5_w0");
        for (int i = 1; i < 4; i++) chk_beat(base + i, 8'(PADV), (i == 3), 1'b1, "t5_pad");
        chk("t5_pad_start", 32'(getcyc(base + 1)), 32'(c0 + 19));
        chk("t5_pad_b2b", 32'(getcyc(base + 3) - getcyc(base + 1)), 32'd2);
        @(negedge clk);
        chk("t5_busy_done", 32'(busy), 32'd0);
`else
        repeat (30) @(negedge clk);
        chk("t5_starved_count", 32'(rx_q.size()), 32'(base + 1));
        chk("t5_still_busy", 32'(busy), 32'd1);
        chk_beat(base, 8'h50, 1'b0, 1'b0, "t5_w0");
        for (int i = 1; i < 4; i++) fifo_push(8'(8'h50 + i));
        wait_rx(base + 4, 20, "t5_timeout");
        for (int i = 1; i < 4; i++) chk_beat(base + i, 8'(8'h50 + i), (i == 3), 1'b0, "t5_refill");
        @(negedge clk);
        chk("t5_busy_done", 32'(busy), 32'd0);
`endif

        // T6: reset with two beats buffered, then a clean packet
        s_if.m_ready = 1'b0;
        for (int i = 0; i < 4; i++) fifo_push(8'(8'h60 + i));
        p0 = pop_cnt;
        pulse_start(8'd4, c0);
        repeat (4) @(negedge clk);
        chk("t6_buffered_valid", 32'(s_if.m_valid), 32'd1);
        chk("t6_buffered_pops", 32'(pop_cnt - p0), 32'd2);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(s_if.m_valid), 32'd0);
        chk("t6_rst_busy",  32'(busy),         32'd0);
        chk("t6_rst_last",  32'(s_if.m_last),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("t6_fifo_left", 32'(fifo_q.size()), 32'd2);
        s_if.m_ready = 1'b1;
        base = rx_q.size();
        pulse_start(8'd2, c0);
        wait_rx(base + 2, 20, "t6_timeout");
        chk_beat(base,     8'h62, 1'b0, 1'b0, "t6_w0");
        chk_beat(base + 1, 8'h63, 1'b1, 1'b0, "t6_w1");

        repeat (2) @(negedge clk);
        chk("rd_en_while_empty", 32'(viol_empty), 32'd0);
        chk("rd_en_while_idle",  32'(viol_idle),  32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
